dmg_mbc1: RTL and testbench

//  Cartridge-side responder for the DMG CPU bus: an MBC1 memory bank controller.
//  - Decodes CPU reads/writes in 0000-7FFF and A000-BFFF.
//  - Holds the bank registers and drives the banked address to the cartridge sync ROM.
//  - Returns read data one cycle after the request.
//  - Sits between dmg_main's cartridge bus and the cartridge ROM/RAM macros.

---
 rtl/dmg_pkg.sv | 32 +++
 rtl/dmg_mbc1_if.sv | 22 ++
 rtl/dmg_cart_ram.sv | 23 ++
 rtl/dmg_mbc1.sv | 113 +++++++++++
 tb/tb_dmg_mbc1.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmg_pkg.sv
// Shared types and constants for the DMG MBC1 cartridge controller:
// bus region tags, MBC register-window bases and banking field widths.
package dmg_pkg;

  typedef enum logic [1:0] {
    REG_ROM0 = 2'd0,
    REG_ROMX = 2'd1,
    REG_RAM  = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  // Write windows inside 0000-7FFF; only bits [14:13] distinguish them.
  localparam logic [15:0] MBC_RAMEN_BASE = 16'h0000;
  localparam logic [15:0] MBC_BANK5_BASE = 16'h2000;
  localparam logic [15:0] MBC_BANK2_BASE = 16'h4000;
  localparam logic [15:0] MBC_MODE_BASE  = 16'h6000;
  localparam logic [15:0] CART_RAM_BASE  = 16'hA000;

  localparam logic [3:0] RAM_ENABLE_KEY = 4'hA;

  localparam int ROM_BANK_AW = 14;
  localparam int RAM_BANK_AW = 13;
  localparam int ROM_FULL_AW = 2 + 5 + ROM_BANK_AW;
  localparam int RAM_FULL_AW = 2 + RAM_BANK_AW;

  function automatic region_e decode_region(input logic [15:0] addr);
    if (addr[15] == 1'b0) return addr[14] ? REG_ROMX : REG_ROM0;
    if (addr[15:13] == CART_RAM_BASE[15:13]) return REG_RAM;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/dmg_mbc1_if.sv
// CPU-side cartridge bus between dmg_main (master) and the MBC1 (slave).
interface dmg_mbc1_if;
  // cpu_wr / cpu_rd are single-cycle strobes sampled on the rising clock edge;
  // each accepted cpu_rd (rd without wr) yields exactly one cpu_rvalid pulse on
  // the following cycle, with cpu_rdata valid only while cpu_rvalid is high.
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;

  modport master (
    output cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
    input  cpu_rdata, cpu_rvalid
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
    output cpu_rdata, cpu_rvalid
  );
endinterface

// File: rtl/dmg_cart_ram.sv
// Single-port synchronous cartridge RAM, byte write, 1-cycle read latency.
// Only exists in builds with CART_RAM_EN defined.
`ifdef CART_RAM_EN
module dmg_cart_ram #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [2**AW];

  // Read returns the pre-write contents when read and write share a cycle.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule
`endif

// File: rtl/dmg_mbc1.sv
// MBC1 bank controller: bank registers, banked sync-ROM addressing and a
// 1-deep read pipe. Define CART_RAM_EN to build the A000-BFFF cartridge RAM.
module dmg_mbc1
  import dmg_pkg::*;
#(
  parameter int ROM_AW = 15,
  parameter int RAM_AW = 15
) (
  input  logic              clk,
  input  logic              rst,
  dmg_mbc1_if.slave         bus,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data
);

  logic       r_ram_en;
  logic [4:0] r_bank5;
  logic [1:0] r_bank2;
  logic       r_mode;
  region_e    r_tag;
  logic       r_rvalid;

  region_e                w_region;
  logic                   w_rd_acc;
  logic [ROM_FULL_AW-1:0] w_rom_full;
  logic [7:0]             w_ram_q;
  logic [7:0]             w_rdata;
  logic                   w_unused;

  assign w_region = decode_region(bus.cpu_addr);
  // A write in the same cycle wins; the read is dropped entirely.
  assign w_rd_acc = bus.cpu_rd & ~bus.cpu_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_en <= 1'b0;
      r_bank5  <= 5'd1;
      r_bank2  <= 2'd0;
      r_mode   <= 1'b0;
      r_tag    <= REG_NONE;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (!w_rd_acc) begin
        r_tag <= REG_NONE;
      end else if (w_region == REG_RAM && !r_ram_en) begin
        r_tag <= REG_NONE;
      end else begin
        r_tag <= w_region;
      end

      if (bus.cpu_wr && !bus.cpu_addr[15]) begin
        case (bus.cpu_addr[14:13])
          MBC_RAMEN_BASE[14:13]: r_ram_en <= (bus.cpu_wdata[3:0] == RAM_ENABLE_KEY);
          MBC_BANK5_BASE[14:13]: r_bank5  <= (bus.cpu_wdata[4:0] == 5'd0) ? 5'd1
                                                                         : bus.cpu_wdata[4:0];
          MBC_BANK2_BASE[14:13]: r_bank2  <= bus.cpu_wdata[1:0];
          MBC_MODE_BASE[14:13]:  r_mode   <= bus.cpu_wdata[0];
          default: ;
        endcase
      end
    end
  end

  // Banked ROM address is purely combinational so the sync ROM sees it in the request cycle.
  always_comb begin
    w_rom_full = {{(ROM_FULL_AW - ROM_BANK_AW){1'b0}}, bus.cpu_addr[ROM_BANK_AW-1:0]};
    if (bus.cpu_addr[14]) begin
      w_rom_full = {r_bank2, r_bank5, bus.cpu_addr[ROM_BANK_AW-1:0]};
    end else if (r_mode) begin
      w_rom_full = {r_bank2, 5'd0, bus.cpu_addr[ROM_BANK_AW-1:0]};
    end
  end

  assign rom_addr = w_rom_full[ROM_AW-1:0];

`ifdef CART_RAM_EN
  logic [RAM_FULL_AW-1:0] w_ram_full;
  logic                   w_ram_we;

  assign w_ram_full = {(r_mode ? r_bank2 : 2'b00), bus.cpu_addr[RAM_BANK_AW-1:0]};
  assign w_ram_we   = bus.cpu_wr & r_ram_en & (w_region == REG_RAM);

  dmg_cart_ram #(
    .AW(RAM_AW)
  ) u_cart_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_full[RAM_AW-1:0]),
    .i_wdata (bus.cpu_wdata),
    .o_rdata (w_ram_q)
  );

  assign w_unused = &{1'b0, w_ram_full, w_rom_full};
`else
  assign w_ram_q  = 8'hFF;
  assign w_unused = &{1'b0, bus.cpu_wdata[7:5], w_rom_full, (RAM_AW > 0)};
`endif

  always_comb begin
    w_rdata = 8'hFF;
    case (r_tag)
      REG_ROM0, REG_ROMX: w_rdata = rom_data;
      REG_RAM:            w_rdata = w_ram_q;
      default:            w_rdata = 8'hFF;
    endcase
  end

  // Reset during the response cycle kills the pending result immediately.
  assign bus.cpu_rvalid = r_rvalid & ~rst;
  assign bus.cpu_rdata  = rst ? 8'hFF : w_rdata;

endmodule

// File: tb/tb_dmg_mbc1.sv
// Bench for dmg_mbc1: two instances (32 KiB and 2 MiB ROM) driven in lockstep
// against a bank-arithmetic reference model and a synchronous ROM model.
module tb_dmg_mbc1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmg_mbc1_if bus15();
  dmg_mbc1_if bus21();

  logic [14:0] rom_addr15;
  logic [7:0]  rom_data15;
  logic [20:0] rom_addr21;
  logic [7:0]  rom_data21;

  dmg_mbc1 #(.ROM_AW(15), .RAM_AW(15)) u_dut15 (
    .clk(clk), .rst(rst), .bus(bus15), .rom_addr(rom_addr15), .rom_data(rom_data15)
  );
  dmg_mbc1 #(.ROM_AW(21), .RAM_AW(15)) u_dut21 (
    .clk(clk), .rst(rst), .bus(bus21), .rom_addr(rom_addr21), .rom_data(rom_data21)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- ROM contents and sync ROM model ----------------
  function automatic logic [7:0] rom_byte(input int a);
    int v;
    v = (a * 37) ^ (a >> 7) ^ (a >> 15) ^ 'h5A;
    return v[7:0];
  endfunction

  always @(posedge clk) begin
    rom_data15 <= rom_byte(int'(rom_addr15));
    rom_data21 <= rom_byte(int'(rom_addr21));
  end

  // ---------------- reference model ----------------
  bit         m_ram_en;
  int         m_bank5, m_bank2, m_mode;
  logic [7:0] m_ram [int];

  logic [7:0] exp_q15[$];
  logic [7:0] exp_q21[$];
  bit         exp_k[$];
  logic [7:0] e_d15, e_d21;
  bit         e_k;
  logic [14:0] e_rom15;
  logic [20:0] e_rom21;
  bit         cur_acc, prev_acc;

  task automatic model_reset();
    m_ram_en = 0; m_bank5 = 1; m_bank2 = 0; m_mode = 0;
    exp_q15.delete(); exp_q21.delete(); exp_k.delete();
    cur_acc = 0; prev_acc = 0;
  endtask

  function automatic int ram_index(input int a);
    return ((m_mode != 0 ? m_bank2 * 8192 : 0) + a % 8192) % 32768;
  endfunction

  function automatic int exp_rom(input int a, input int aw);
    int bank;
    if (a >= 'h4000) bank = m_bank2 * 32 + m_bank5;
    else if (m_mode != 0) bank = m_bank2 * 32;
    else bank = 0;
    return (bank * 16384 + a % 16384) % (1 << aw);
  endfunction

  task automatic exp_read(input int a, input int aw, output logic [7:0] v, output bit k);
    k = 1; v = 8'hFF;
    if (a < 'h8000) v = rom_byte(exp_rom(a, aw));
    else if (a >= 'hA000 && a < 'hC000 && m_ram_en) begin
`ifdef CART_RAM_EN
      if (m_ram.exists(ram_index(a))) v = m_ram[ram_index(a)];
      else k = 0;
`endif
    end
  endtask

  task automatic model_write(input int a, input int d);
    if (a < 'h2000) m_ram_en = (d % 16 == 10);
    else if (a < 'h4000) m_bank5 = (d % 32 == 0) ? 1 : d % 32;
    else if (a < 'h6000) m_bank2 = d % 4;
    else if (a < 'h8000) m_mode = d % 2;
    else if (a >= 'hA000 && a < 'hC000 && m_ram_en) begin
`ifdef CART_RAM_EN
      m_ram[ram_index(a)] = d[7:0];
`endif
    end
  endtask

  task automatic pop_exp();
    e_d15 = exp_q15.pop_front();
    e_d21 = exp_q21.pop_front();
    e_k   = exp_k.pop_front();
  endtask

  // ---------------- driver ----------------
  task automatic set_idle();
    bus15.cpu_addr = '0; bus15.cpu_wdata = '0; bus15.cpu_wr = 0; bus15.cpu_rd = 0;
    bus21.cpu_addr = '0; bus21.cpu_wdata = '0; bus21.cpu_wr = 0; bus21.cpu_rd = 0;
  endtask

  // One bus cycle; returns #1 after the inputs settle so tests can sample.
  task automatic drive(input int a, input int d, input bit wr, input bit rd);
    logic [7:0] v15, v21;
    bit k;
    @(negedge clk);
    bus15.cpu_addr = a[15:0]; bus15.cpu_wdata = d[7:0]; bus15.cpu_wr = wr; bus15.cpu_rd = rd;
    bus21.cpu_addr = a[15:0]; bus21.cpu_wdata = d[7:0]; bus21.cpu_wr = wr; bus21.cpu_rd = rd;
    prev_acc = cur_acc;
    cur_acc  = rd && !wr;
    e_rom15  = 15'(exp_rom(a, 15));
    e_rom21  = 21'(exp_rom(a, 21));
    if (cur_acc) begin
      exp_read(a, 15, v15, k);
      exp_read(a, 21, v21, k);
      exp_q15.push_back(v15);
      exp_q21.push_back(v21);
      exp_k.push_back(k);
    end
    if (wr) model_write(a, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus15.cpu_rvalid !== 1'b0 || bus21.cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_rvalid got %b/%b exp 0", bus15.cpu_rvalid, bus21.cpu_rvalid);
    end
    checks++;
    if (bus15.cpu_rdata !== 8'hFF || bus21.cpu_rdata !== 8'hFF) begin
      errors++; $display("FAIL reset_rdata got %h/%h exp ff", bus15.cpu_rdata, bus21.cpu_rdata);
    end
    drive('h4000, 0, 0, 1);
    checks++;
    if (rom_addr15 !== 15'h4000 || rom_addr21 !== 21'h004000) begin
      errors++; $display("FAIL first_rom_addr got %h/%h exp 4000", rom_addr15, rom_addr21);
    end
    drive(0, 0, 0, 0);
    pop_exp();
    checks++;
    if (bus15.cpu_rvalid !== 1'b1 || bus15.cpu_rdata !== rom_byte('h4000) ||
        bus21.cpu_rvalid !== 1'b1 || bus21.cpu_rdata !== rom_byte('h4000)) begin
      errors++; $display("FAIL first_read got %b %h / %b %h exp 1 %h", bus15.cpu_rvalid,
                         bus15.cpu_rdata, bus21.cpu_rvalid, bus21.cpu_rdata, rom_byte('h4000));
    end
    drive(0, 0, 0, 0);
    checks++;
    if (bus15.cpu_rvalid !== 1'b0 || bus21.cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL rvalid_single_pulse got %b/%b exp 0", bus15.cpu_rvalid, bus21.cpu_rvalid);
    end
  endtask

  task automatic test_rom_banking();
    drive('h2000, 'h00, 1, 0);
    drive('h4123, 0, 0, 1);
    checks++;
    if (rom_addr21 !== 21'h004123 || rom_addr15 !== 15'h4123) begin
      errors++; $display("FAIL bank0_remap got %h/%h exp 4123", rom_addr15, rom_addr21);
    end
    drive('h2000, 'h05, 1, 0);
    pop_exp();
    checks++;
    if (bus21.cpu_rvalid !== 1'b1 || bus21.cpu_rdata !== rom_byte('h4123) ||
        bus15.cpu_rdata !== rom_byte('h4123)) begin
      errors++; $display("FAIL read_before_bankwrite got %h/%h exp %h", bus15.cpu_rdata,
                         bus21.cpu_rdata, rom_byte('h4123));
    end
    drive('h4000, 'h02, 1, 0);
    drive('h7FFF, 0, 0, 1);
    checks++;
    if (rom_addr21 !== 21'h117FFF || rom_addr15 !== 15'h7FFF) begin
      errors++; $display("FAIL bank_69 got %h/%h exp 7fff/117fff", rom_addr15, rom_addr21);
    end
    drive('h6000, 'h01, 1, 0);
    pop_exp();
    checks++;
    if (bus21.cpu_rdata !== rom_byte('h117FFF) || bus15.cpu_rdata !== rom_byte('h7FFF)) begin
      errors++; $display("FAIL bank_69_data got %h/%h exp %h/%h", bus15.cpu_rdata,
                         bus21.cpu_rdata, rom_byte('h7FFF), rom_byte('h117FFF));
    end
    drive('h0000, 0, 0, 1);
    checks++;
    if (rom_addr21 !== 21'h100000 || rom_addr15 !== 15'h0000) begin
      errors++; $display("FAIL mode1_rom0 got %h/%h exp 0/100000", rom_addr15, rom_addr21);
    end
    drive('h2000, 'h03, 1, 0);
    pop_exp();
    drive('h4000, 0, 0, 1);
    checks++;
    if (rom_addr15 !== 15'h4000 || rom_addr21 !== 21'h10C000) begin
      errors++; $display("FAIL bank_wrap got %h/%h exp 4000/10c000", rom_addr15, rom_addr21);
    end
    drive(0, 0, 0, 0);
    pop_exp();
    checks++;
    if (bus15.cpu_rdata !== e_d15 || bus21.cpu_rdata !== e_d21) begin
      errors++; $display("FAIL bank_wrap_data got %h/%h exp %h/%h", bus15.cpu_rdata,
                         bus21.cpu_rdata, e_d15, e_d21);
    end
  endtask

  task automatic test_rdwr_collision();
    drive('h2000, 'h04, 1, 1);
    drive('h4000, 0, 0, 1);
    checks++;
    if (bus15.cpu_rvalid !== 1'b0 || bus21.cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL rdwr_drop got %b/%b exp 0", bus15.cpu_rvalid, bus21.cpu_rvalid);
    end
    checks++;
    if (rom_addr15 !== e_rom15 || rom_addr21 !== e_rom21) begin
      errors++; $display("FAIL rdwr_write_done got %h/%h exp %h/%h", rom_addr15, rom_addr21,
                         e_rom15, e_rom21);
    end
    drive(0, 0, 0, 0);
    pop_exp();
  endtask

  task automatic test_back_to_back();
    int a;
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 'h7FFF);
      if (i < 10) drive(a, 0, 0, 1);
      else drive(0, 0, 0, 0);
      if (i < 10) begin
        checks++;
        if (rom_addr15 !== e_rom15 || rom_addr21 !== e_rom21) begin
          errors++; $display("FAIL b2b_addr[%0d] got %h/%h exp %h/%h", i, rom_addr15, rom_addr21,
                             e_rom15, e_rom21);
        end
      end
      if (i > 0) begin
        checks++;
        if (prev_acc) begin
          pop_exp();
          if (bus15.cpu_rvalid !== 1'b1 || bus15.cpu_rdata !== e_d15 ||
              bus21.cpu_rvalid !== 1'b1 || bus21.cpu_rdata !== e_d21) begin
            errors++; $display("FAIL b2b_data[%0d] got %b %h/%b %h exp %h/%h", i, bus15.cpu_rvalid,
                               bus15.cpu_rdata, bus21.cpu_rvalid, bus21.cpu_rdata, e_d15, e_d21);
          end
        end else if (bus15.cpu_rvalid !== 1'b0 || bus21.cpu_rvalid !== 1'b0) begin
          errors++; $display("FAIL b2b_idle[%0d] got %b/%b exp 0", i, bus15.cpu_rvalid, bus21.cpu_rvalid);
        end
      end
    end
  endtask

  task automatic test_cart_ram();
    logic [7:0] hit;
`ifdef CART_RAM_EN
    hit = 8'h5A;
`else
    hit = 8'hFF;
`endif
    do_reset();
    drive('hA000, 0, 0, 1);
    drive('h0000, 'h0A, 1, 0);
    pop_exp();
    checks++;
    if (bus15.cpu_rvalid !== 1'b1 || bus15.cpu_rdata !== 8'hFF || bus21.cpu_rdata !== 8'hFF) begin
      errors++; $display("FAIL ram_disabled got %b %h/%h exp 1 ff", bus15.cpu_rvalid,
                         bus15.cpu_rdata, bus21.cpu_rdata);
    end
    drive('hA010, 'h5A, 1, 0);
    drive('hA010, 0, 0, 1);
    drive(0, 0, 0, 0);
    pop_exp();
    checks++;
    if (bus15.cpu_rvalid !== 1'b1 || bus15.cpu_rdata !== hit || bus21.cpu_rdata !== hit) begin
      errors++; $display("FAIL ram_enabled got %b %h/%h exp 1 %h", bus15.cpu_rvalid,
                         bus15.cpu_rdata, bus21.cpu_rdata, hit);
    end
    drive('h0000, 'h00, 1, 0);
    drive('hA010, 0, 0, 1);
    drive(0, 0, 0, 0);
    pop_exp();
    checks++;
    if (bus15.cpu_rdata !== 8'hFF || bus21.cpu_rdata !== 8'hFF) begin
      errors++; $display("FAIL ram_redisabled got %h/%h exp ff", bus15.cpu_rdata, bus21.cpu_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    drive('h2000, 'h07, 1, 0);
    drive('h4000, 'h03, 1, 0);
    drive('h6000, 'h01, 1, 0);
    drive('h0000, 'h0A, 1, 0);
    drive('h4000, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    #1;
    checks++;
    if (bus15.cpu_rvalid !== 1'b0 || bus21.cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_read got %b/%b exp 0", bus15.cpu_rvalid, bus21.cpu_rvalid);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus15.cpu_rvalid !== 1'b0 || bus21.cpu_rdata !== 8'hFF) begin
      errors++; $display("FAIL rst_read_lost got %b %h exp 0 ff", bus15.cpu_rvalid, bus21.cpu_rdata);
    end
    drive('h4000, 0, 0, 1);
    checks++;
    if (rom_addr21 !== 21'h004000 || rom_addr15 !== 15'h4000) begin
      errors++; $display("FAIL rst_banks got %h/%h exp 4000", rom_addr15, rom_addr21);
    end
    drive('h0123, 0, 0, 1);
    pop_exp();
    checks++;
    if (rom_addr21 !== 21'h000123) begin
      errors++; $display("FAIL rst_mode got %h exp 000123", rom_addr21);
    end
    drive('hA010, 0, 0, 1);
    pop_exp();
    drive(0, 0, 0, 0);
    pop_exp();
    checks++;
    if (bus15.cpu_rvalid !== 1'b1 || bus15.cpu_rdata !== 8'hFF || bus21.cpu_rdata !== 8'hFF) begin
      errors++; $display("FAIL rst_ram_en got %b %h/%h exp 1 ff", bus15.cpu_rvalid,
                         bus15.cpu_rdata, bus21.cpu_rdata);
    end
  endtask

  task automatic test_random();
    int a, d, r;
    bit wr, rd;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 'h1FFF);
        1: a = $urandom_range('h2000, 'h3FFF);
        2: a = $urandom_range('h4000, 'h5FFF);
        3: a = $urandom_range('h6000, 'h7FFF);
        4: a = 'hA000 + $urandom_range(0, 15);
        default: a = $urandom_range(0, 'hFFFF);
      endcase
      d = $urandom_range(0, 255);
      if (a < 'h2000 && $urandom_range(0, 1) == 1) d = 'h0A;
      wr = (r >= 6);
      rd = (r < 6) || (r == 9);
      drive(a, d, wr, rd);
      if (cur_acc && a < 'h8000) begin
        checks++;
        if (rom_addr15 !== e_rom15 || rom_addr21 !== e_rom21) begin
          errors++; $display("FAIL rnd_addr[%0d] a=%h got %h/%h exp %h/%h", i, a, rom_addr15,
                             rom_addr21, e_rom15, e_rom21);
        end
      end
      checks++;
      if (prev_acc) begin
        pop_exp();
        if (bus15.cpu_rvalid !== 1'b1 || bus21.cpu_rvalid !== 1'b1 ||
            (e_k && (bus15.cpu_rdata !== e_d15 || bus21.cpu_rdata !== e_d21))) begin
          errors++; $display("FAIL rnd_data[%0d] got %b %h/%b %h exp 1 %h/%h", i, bus15.cpu_rvalid,
                             bus15.cpu_rdata, bus21.cpu_rvalid, bus21.cpu_rdata, e_d15, e_d21);
        end
      end else if (bus15.cpu_rvalid !== 1'b0 || bus21.cpu_rvalid !== 1'b0) begin
        errors++; $display("FAIL rnd_idle[%0d] got %b/%b exp 0", i, bus15.cpu_rvalid, bus21.cpu_rvalid);
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    test_reset();
    test_rom_banking();
    test_rdwr_collision();
    test_back_to_back();
    test_cart_ram();
    test_reset_mid_read();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
